axis_y_reorder: RTL and testbench
=================================

// Module: axis_y_reorder
// PURPOSE
//  Sits on the master side of axis_sa. Takes the array's result stream: one
//  beat per output column, R words per beat, last column first. Buffers one
//  full R x C tile of Y. Re-emits it row-major: one beat per row, C words per
//  beat, col 0 in the LSBs. Both sides are AXI-Stream.
// PARAMETERS
//  R   2   rows of the array = words per input beat = output beats per tile
//  C   2   cols of the array = input beats per tile = words per output beat
//  WY  10  result word width in bits (WX+WK+clog2(K) at the array)
// PORTS
//  clk      in   1     clock; everything is rising-edge
//  rst      in   1     async reset, active-high
//  s_valid  in   1     input beat valid
//  s_ready  out  1     input beat accepted when s_valid & s_ready
//  s_last   in   1     end of tile marker from the array
//  s_data   in   R*WY  word r at [r*WY +: WY] = Y[r][col of this beat]
//  m_valid  out  1     output beat valid
//  m_ready  in   1     downstream ready
//  m_last   out  1     high on the last row beat of a tile
//  m_data   out  C*WY  word c at [c*WY +: WY] = Y[row][c]
//  err      out  1     present only with AXIS_Y_REORDER_CHK_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, takes effect immediately):
//    - state = FILL; col_cnt = 0; row_cnt = 0
//    - s_ready = 0, m_valid = 0, m_last = 0, err = 0
//    - buffer contents are not cleared (don't-care)
//  - First rising edge with rst low: s_ready goes to 1.
//  - Outputs s_ready, m_valid, m_last and m_data are registered.
//  - FILL state:
//    - s_ready = 1, m_valid = 0.
//    - Each accepted beat i (col_cnt = i) writes buf[r][C-1-i] = s_data word r,
//      for all r.
//    - Then col_cnt increments.
//    - On accepting beat C-1:
//      - col_cnt wraps to 0 and state goes to DRAIN.
//      - s_ready = 0 and m_valid = 1 from the next cycle.
//      - Latency: 1 cycle.
//  - DRAIN state:
//    - s_ready = 0.
//    - m_data = buf[row_cnt][C-1:0]; m_last = (row_cnt == R-1).
//    - On an m handshake, row_cnt increments and the next row is presented the
//      next cycle. There are no bubbles.
//    - Handshake on row R-1: row_cnt wraps to 0 and state goes to FILL.
//      m_valid = 0 and s_ready = 1 from the next cycle.
//  - Backpressure:
//    - While m_valid & ~m_ready, m_data and m_last hold stable.
//    - m_valid never drops without a handshake.
//  - Throughput: C + R cycles per tile minimum. No overlap of fill and drain.
//  - s_valid gaps in FILL simply stall col_cnt. No timeout.
//  - s_last never alters framing. A tile is exactly C accepted beats.
//  - Data words are passed bit-exact. No sign extension or arithmetic.
//  - Reset mid-FILL or mid-DRAIN: the partial tile is discarded.
//    - The first beat accepted after reset is column C-1 of a new tile.
// CONFIGURATION
//  - AXIS_Y_REORDER_CHK_EN defined:
//    - Port err exists.
//    - err is set sticky, one cycle after any accepted beat where
//      s_last != (col_cnt == C-1).
//    - err is cleared only by rst.
//    - Data flow is unaffected.
//  - AXIS_Y_REORDER_CHK_EN undefined: no err port, s_last is ignored entirely,
//    no extra logic.
// TESTING
//  Default params, tile Y = [[-15,6],[25,12]].
//  1. Basic tile:
//     - Stimulus: m_ready=1; input beats {6,12} then {-15,25}, s_last on beat 2.
//     - Response: m beats {-15,6} then {25,12}, m_last on beat 2.
//     - First m_valid comes 1 cycle after the 2nd input handshake.
//  2. Backpressure:
//     - Stimulus: as test 1, with m_ready low 3 cycles at the first m_valid.
//     - Response: m_data = {-15,6} and m_last = 0 stable throughout; s_ready = 0.
//  3. Back-to-back tiles:
//     - Stimulus: s_valid held high across 2 tiles.
//     - Response: s_ready = 0 for exactly the R drain cycles.
//     - Both tiles are output intact; no input beat is lost or duplicated.
//  4. Reset mid-fill:
//     - Stimulus: assert rst after 1 accepted beat, then send a full new tile.
//     - Response: m_valid = 0 immediately; the new tile is output correctly.
//  5. Check feature (with CHK_EN):
//     - Stimulus: s_last = 1 on beat 1.
//     - Response: err = 1 next cycle and stays 1; outputs still match test 1.
//     - Without CHK_EN the same outputs are produced.
//  6. Random s_valid / m_ready (50%), 100 tiles:
//     - Response: output equals the row-major transpose of every tile.

Source files
------------

// File: rtl/axis_y_reorder.sv
// axis_y_reorder: buffers one R x C result tile arriving column-wise (last column first) and re-emits it row-major; optional checker macro AXIS_Y_REORDER_CHK_EN adds a sticky s_last framing error flag on port err
module axis_y_reorder #(
  parameter int R  = 2,
  parameter int C  = 2,
  parameter int WY = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic            s_last,
  input  logic [R*WY-1:0] s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_last,
  output logic [C*WY-1:0] m_data
`ifdef AXIS_Y_REORDER_CHK_EN
  ,
  output logic            err
`endif
);
  localparam int CW = C > 1 ? $clog2(C) : 1;
  localparam int RW = R > 1 ? $clog2(R) : 1;
  localparam logic [CW-1:0] C_MAX = CW'(C - 1);
  localparam logic [RW-1:0] R_MAX = RW'(R - 1);
  typedef enum logic {FILL, DRAIN} state_t;
  state_t state, state_n;
  logic [CW-1:0] col_cnt, col_n;
  logic [RW-1:0] row_cnt, row_n;
  logic s_ready_n, m_valid_n, m_last_n;
  logic [C*WY-1:0] m_data_n, row0;
  logic [C*WY-1:0] mem [R];
  logic s_hs, m_hs, last_col, last_row;
  assign s_hs     = s_valid & s_ready;
  assign m_hs     = m_valid & m_ready;
  assign last_col = col_cnt == C_MAX;
  assign last_row = row_cnt == R_MAX;
  // tile storage, written column-reversed so each row reads out with col 0 in the LSBs
  always_ff @(posedge clk)
    if (s_hs)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++)
          if (C_MAX - col_cnt == CW'(c)) mem[r][c*WY +: WY] <= s_data[r*WY +: WY];
  // next state and next registered outputs; the final fill beat bypasses into row 0
  always_comb begin
    state_n   = state;
    col_n     = col_cnt;
    row_n     = row_cnt;
    s_ready_n = s_ready;
    m_valid_n = m_valid;
    m_last_n  = m_last;
    m_data_n  = m_data;
    row0      = mem[0];
    row0[WY-1:0] = s_data[WY-1:0];
    if (state == FILL) begin
      s_ready_n = 1'b1;
      if (s_hs) begin
        col_n = last_col ? '0 : col_cnt + 1'b1;
        if (last_col) begin
          state_n   = DRAIN;
          s_ready_n = 1'b0;
          m_valid_n = 1'b1;
          m_data_n  = row0;
          m_last_n  = R == 1;
        end
      end
    end else if (m_hs) begin
      row_n    = last_row ? '0 : row_cnt + 1'b1;
      m_data_n = mem[row_n];
      m_last_n = row_n == R_MAX;
      if (last_row) begin
        state_n   = FILL;
        m_valid_n = 1'b0;
        m_last_n  = 1'b0;
        s_ready_n = 1'b1;
      end
    end
  end
  // control and output registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= FILL;
      col_cnt <= '0;
      row_cnt <= '0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else begin
      state   <= state_n;
      col_cnt <= col_n;
      row_cnt <= row_n;
      s_ready <= s_ready_n;
      m_valid <= m_valid_n;
      m_last  <= m_last_n;
      m_data  <= m_data_n;
    end
`ifdef AXIS_Y_REORDER_CHK_EN
  // sticky framing error: s_last must mark exactly the final column beat of a tile
  always_ff @(posedge clk or posedge rst)
    if (rst) err <= 1'b0;
    else if (s_hs && (s_last != last_col)) err <= 1'b1;
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
`endif
endmodule

// File: tb/tb_axis_y_reorder.sv
// tb_axis_y_reorder: directed and random tiles checked against a transpose model
module tb_axis_y_reorder;
  localparam int R = 2, C = 2, WY = 10;
  logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, s_last = 1'b0;
  logic m_force = 1'b0, rnd = 1'b0, rand_mode = 1'b0;
  logic [R*WY-1:0] s_data = '0;
  logic s_ready, m_valid, m_last, m_ready;
  logic [C*WY-1:0] m_data;
`ifdef AXIS_Y_REORDER_CHK_EN
  logic err;
`endif
  int tests = 0, fails = 0, got = 0, out_beats = 0, tiles = 0;
  typedef struct {logic [C*WY-1:0] d; logic l;} beat_t;
  beat_t expq[$];
  beat_t mb, pb;
  logic [WY-1:0] cols [C][R];
  logic [WY-1:0] y [R][C];
  logic prev_stall = 1'b0, prev_l = 1'b0;
  logic [C*WY-1:0] prev_d = '0;

  assign m_ready = rand_mode ? rnd : m_force;
  always #5 clk = ~clk;
  always begin
    @(posedge clk);
    #1;
    rnd = 1'($urandom_range(0, 1));
  end

  axis_y_reorder #(.R(R), .C(C), .WY(WY)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_data(m_data)
`ifdef AXIS_Y_REORDER_CHK_EN
    , .err(err)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // model: collect C accepted column beats, then expect the R rows of the transpose
  always @(negedge clk) begin
    if (rst) begin
      got = 0;
      out_beats = 0;
      expq.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(m_valid), 64'd1);
        chk("hold_data", 64'(m_data), 64'(prev_d));
        chk("hold_last", 64'(m_last), 64'(prev_l));
      end
      if (m_valid && m_ready) begin
        out_beats++;
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got 0x%0h, want no beat", m_data);
        end else begin
          pb = expq.pop_front();
          chk("m_data", 64'(m_data), 64'(pb.d));
          chk("m_last", 64'(m_last), 64'(pb.l));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      prev_l = m_last;
      if (s_valid && s_ready) begin
        for (int r = 0; r < R; r++) cols[got][r] = s_data[r*WY +: WY];
        got++;
        if (got == C) begin
          got = 0;
          for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) mb.d[c*WY +: WY] = cols[C-1-c][r];
            mb.l = r == R - 1;
            expq.push_back(mb);
          end
        end
      end
    end
  end

  function automatic logic [R*WY-1:0] col_beat(input int i);
    logic [R*WY-1:0] d;
    for (int r = 0; r < R; r++) d[r*WY +: WY] = y[r][C-1-i];
    return d;
  endfunction

  task automatic send_beat(input logic [R*WY-1:0] d, input logic l);
    logic hs;
    int n;
    s_data = d;
    s_last = l;
    s_valid = 1'b1;
    hs = 1'b0;
    n = 0;
    while (!hs && n < 1000) begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk);
      n++;
    end
    if (!hs) chk("s_handshake_timeout", 64'(hs), 64'd1);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_tile(input logic gaps);
    for (int i = 0; i < C; i++) begin
      if (gaps) idle($urandom_range(0, 1));
      send_beat(col_beat(i), i == C - 1);
    end
    idle(0);
    tiles++;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (expq.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    idle(2);
    chk("drain_empty", 64'(expq.size()), 64'd0);
  endtask

  task automatic rand_tile();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) y[r][c] = WY'($urandom);
  endtask

  task automatic base_tile();
    y[0][0] = 10'h3F1;
    y[0][1] = 10'd6;
    y[1][0] = 10'd25;
    y[1][1] = 10'd12;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int n;
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
`ifdef AXIS_Y_REORDER_CHK_EN
    chk("rst_err", 64'(err), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("first_edge_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    // test 1: basic tile, pinned literals
    m_force = 1'b1;
    base_tile();
    chk("t1_in_beat0", 64'(col_beat(0)), 64'h03006);
    chk("t1_in_beat1", 64'(col_beat(1)), 64'h067F1);
    send_tile(1'b0);
    @(negedge clk);
    chk("t1_row0_valid", 64'(m_valid), 64'd1);
    chk("t1_row0_data", 64'(m_data), 64'h01BF1);
    chk("t1_row0_last", 64'(m_last), 64'd0);
    chk("t1_drain_s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    chk("t1_row1_data", 64'(m_data), 64'h03019);
    chk("t1_row1_last", 64'(m_last), 64'd1);
    @(negedge clk);
    chk("t1_end_valid", 64'(m_valid), 64'd0);
    chk("t1_end_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    // test 2: backpressure on the first row
    m_force = 1'b0;
    send_tile(1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t2_valid", 64'(m_valid), 64'd1);
      chk("t2_data", 64'(m_data), 64'h01BF1);
      chk("t2_last", 64'(m_last), 64'd0);
      chk("t2_s_ready", 64'(s_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    m_force = 1'b1;
    wait_drain();
    // test 3: back-to-back tiles with s_valid held high
    rand_tile();
    send_beat(col_beat(0), 1'b0);
    send_beat(col_beat(1), 1'b1);
    rand_tile();
    s_data = col_beat(0);
    s_last = 1'b0;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("t3_stall_cycles", 64'(n), 64'(R));
    @(posedge clk);
    #1;
    send_beat(col_beat(1), 1'b1);
    idle(0);
    wait_drain();
    // test 4: reset mid-fill, then mid-drain
    rand_tile();
    send_beat(col_beat(0), 1'b0);
    idle(0);
    #2;
    rst = 1'b1;
    #1;
    chk("t4_fill_rst_valid", 64'(m_valid), 64'd0);
    chk("t4_fill_rst_s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_force = 1'b0;
    rand_tile();
    send_tile(1'b0);
    @(negedge clk);
    chk("t4_drain_valid", 64'(m_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t4_drain_rst_valid", 64'(m_valid), 64'd0);
    chk("t4_drain_rst_last", 64'(m_last), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_force = 1'b1;
    tiles = 0;
    rand_tile();
    send_tile(1'b0);
    wait_drain();
    // test 5: s_last on the wrong beat
    base_tile();
`ifdef AXIS_Y_REORDER_CHK_EN
    chk("t5_err_pre", 64'(err), 64'd0);
`endif
    send_beat(col_beat(0), 1'b1);
`ifdef AXIS_Y_REORDER_CHK_EN
    chk("t5_err_set", 64'(err), 64'd1);
`endif
    send_beat(col_beat(1), 1'b1);
    idle(0);
    tiles++;
    @(negedge clk);
    chk("t5_row0_data", 64'(m_data), 64'h01BF1);
    wait_drain();
`ifdef AXIS_Y_REORDER_CHK_EN
    chk("t5_err_sticky", 64'(err), 64'd1);
`endif
    // test 6: random s_valid gaps and m_ready, 100 tiles
    rand_mode = 1'b1;
    for (int t = 0; t < 100; t++) begin
      rand_tile();
      send_tile(1'b1);
    end
    wait_drain();
    chk("out_beat_count", 64'(out_beats), 64'(tiles * R));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
